// File: rtl/user_beacon_pkg.sv
// user_beacon_pkg: shared types and pin constants for the status beacon
package user_beacon_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic [15:0] check;
    logic [3:0]  status;
  } beacon_word_t;
  localparam int CHECK_LSB = 16;
  localparam int STATUS_LSB = 32;
  localparam int PIN_W = STATUS_LSB + 4 - CHECK_LSB;
  localparam int WORD_W = $bits(beacon_word_t);
endpackage

// File: rtl/user_status_beacon_if.sv
// user_status_beacon_if: valid/ready push port carrying one beacon word
interface user_status_beacon_if;
  logic        push_valid;
  logic        push_ready;
  logic [15:0] push_check;
  logic [3:0]  push_status;
  modport master (output push_valid, push_check, push_status, input push_ready);
  modport slave (input push_valid, push_check, push_status, output push_ready);
endinterface

// File: rtl/user_beacon_fifo.sv
// user_beacon_fifo: synchronous FIFO with flush and occupancy count
module user_beacon_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/user_status_beacon.sv
// user_status_beacon: shows queued check/status words on GPIO for a minimum hold time
module user_status_beacon
  import user_beacon_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_W = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 enable,
  input  logic [HOLD_W-1:0]    hold_cycles,
  user_status_beacon_if.slave  push,
  output logic [15:0]          checkbits_o,
  output logic [3:0]           status_o,
  output logic [PIN_W-1:0]     oeb_o,
  output logic                 word_done,
  output logic [7:0]           shown_count
);
  state_t state, state_nxt;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic [$clog2(FIFO_DEPTH):0] unused_count;
  beacon_word_t head;
  logic full, empty, pop, last;
  user_beacon_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .flush(!enable),
    .push(push.push_valid && push.push_ready),
    .pop(pop),
    .wdata({push.push_check, push.push_status}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(unused_count)
  );
  // ready reflects current occupancy only; a same-cycle pop does not free a slot
  assign push.push_ready = enable && !wb_rst_i && !full;
  assign last = state == HOLD && cnt == HOLD_W'(1);
  assign pop = enable && !empty && (state == IDLE || last);
  assign word_done = enable && last;
  always_comb begin
    state_nxt = !enable ? IDLE : pop ? HOLD : last ? IDLE : state;
    cnt_nxt = (!enable || (last && !pop)) ? '0
            : pop ? (hold_cycles == '0 ? HOLD_W'(1) : hold_cycles)
            : state == HOLD ? cnt - HOLD_W'(1) : cnt;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      checkbits_o <= '0;
      status_o <= '0;
      oeb_o <= '1;
      shown_count <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      oeb_o <= {PIN_W{!enable}};
      if (pop) begin
        checkbits_o <= head.check;
        status_o <= head.status;
        shown_count <= shown_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_user_status_beacon.sv
// tb_user_status_beacon: directed self-checking bench for user_status_beacon
module tb_user_status_beacon;
  import user_beacon_pkg::*;
  logic wb_clk_i = 0;
  logic wb_rst_i, enable;
  logic [15:0] hold_cycles;
  logic [15:0] checkbits_o;
  logic [3:0] status_o;
  logic [19:0] oeb_o;
  logic word_done;
  logic [7:0] shown_count;
  int n_chk = 0, n_err = 0;
  int idx;
  logic [19:0] w;
  user_status_beacon_if bus ();
  user_status_beacon dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .enable(enable),
    .hold_cycles(hold_cycles),
    .push(bus),
    .checkbits_o(checkbits_o),
    .status_o(status_o),
    .oeb_o(oeb_o),
    .word_done(word_done),
    .shown_count(shown_count)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge wb_clk_i);
    #1;
  endtask
  task automatic smp();
    @(negedge wb_clk_i);
  endtask
  task automatic do_reset();
    wb_rst_i = 1;
    enable = 1;
    bus.push_valid = 0;
    repeat (3) nxt();
    wb_rst_i = 0;
  endtask
  task automatic drive(logic v, logic [19:0] d);
    bus.push_valid = v;
    {bus.push_check, bus.push_status} = d;
  endtask
  task automatic out_chk(string tag, logic [19:0] d, logic done);
    chk({tag, ".check"}, checkbits_o, d[19:4]);
    chk({tag, ".status"}, status_o, d[3:0]);
    chk({tag, ".done"}, word_done, done);
  endtask
  function automatic logic [19:0] wrd(int k);
    return {16'(16'hC000 + k), 4'(k + 1)};
  endfunction
  initial begin
    wb_rst_i = 1;
    enable = 1;
    hold_cycles = 0;
    drive(0, 20'h0);
    nxt();
    smp();
    out_chk("rst", 20'h0, 0);
    chk("rst.oeb", oeb_o, 20'hFFFFF);
    chk("rst.ready", bus.push_ready, 0);
    chk("rst.shown", shown_count, 0);
    nxt();
    nxt();
    wb_rst_i = 0;
    smp();
    chk("rel.ready", bus.push_ready, 1);
    chk("rel.oeb", oeb_o, 20'hFFFFF);
    nxt();
    smp();
    chk("en.oeb", oeb_o, 20'h0);
    // hold=3, two words back to back
    do_reset();
    hold_cycles = 3;
    for (int i = 0; i < 10; i++) begin
      drive(i < 2, i == 0 ? 20'hAB40A : 20'h19685);
      smp();
      out_chk($sformatf("h3[%0d]", i), i < 2 ? 20'h0 : i < 5 ? 20'hAB40A : 20'h19685, i == 4 || i == 7);
      chk($sformatf("h3.shown[%0d]", i), shown_count, i < 2 ? 0 : i < 5 ? 1 : 2);
      nxt();
    end
    // hold=0 behaves as one cycle per word
    do_reset();
    hold_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      drive(i < 3, i == 0 ? 20'h1DCD5 : i == 1 ? 20'h1DCE5 : 20'hAB51A);
      smp();
      out_chk($sformatf("h0[%0d]", i), i < 2 ? 20'h0 : i == 2 ? 20'h1DCD5 : i == 3 ? 20'h1DCE5 : 20'hAB51A, i >= 2 && i <= 4);
      nxt();
    end
    chk("h0.shown", shown_count, 3);
    // full FIFO backpressure with hold=10
    do_reset();
    hold_cycles = 10;
    idx = 0;
    for (int i = 0; i < 65; i++) begin
      drive(idx < 6, wrd(idx));
      smp();
      chk($sformatf("full.ready[%0d]", i), bus.push_ready, i < 5 || i == 12 || i >= 22);
      w = i < 2 ? 20'h0 : wrd((i - 2) / 10 > 5 ? 5 : (i - 2) / 10);
      out_chk($sformatf("full[%0d]", i), w, i >= 11 && i <= 61 && (i - 11) % 10 == 0);
      if (bus.push_valid && bus.push_ready) idx++;
      nxt();
    end
    chk("full.pushed", idx, 6);
    chk("full.shown", shown_count, 6);
    // abort in second hold cycle with two words queued
    do_reset();
    hold_cycles = 8;
    drive(1, wrd(20));
    nxt();
    drive(1, wrd(21));
    nxt();
    drive(1, wrd(22));
    smp();
    out_chk("ab.c2", wrd(20), 0);
    nxt();
    drive(0, 20'h0);
    enable = 0;
    smp();
    out_chk("ab.c3", wrd(20), 0);
    chk("ab.c3.ready", bus.push_ready, 0);
    chk("ab.c3.oeb", oeb_o, 20'h0);
    nxt();
    smp();
    out_chk("ab.c4", wrd(20), 0);
    chk("ab.c4.oeb", oeb_o, 20'hFFFFF);
    nxt();
    enable = 1;
    smp();
    chk("ab.c5.ready", bus.push_ready, 1);
    chk("ab.c5.oeb", oeb_o, 20'hFFFFF);
    nxt();
    smp();
    out_chk("ab.c6", wrd(20), 0);
    chk("ab.c6.oeb", oeb_o, 20'h0);
    chk("ab.c6.shown", shown_count, 1);
    nxt();
    drive(1, 20'h12343);
    smp();
    out_chk("ab.c7", wrd(20), 0);
    nxt();
    drive(0, 20'h0);
    smp();
    out_chk("ab.c8", wrd(20), 0);
    nxt();
    smp();
    out_chk("ab.c9", 20'h12343, 0);
    chk("ab.c9.shown", shown_count, 2);
    nxt();
    // 257 words at hold=1 wraps shown_count
    do_reset();
    hold_cycles = 1;
    for (int k = 0; k < 259; k++) begin
      drive(k < 257, wrd(k));
      smp();
      if (k >= 2) out_chk($sformatf("wrap[%0d]", k), wrd(k - 2), 1);
      nxt();
    end
    chk("wrap.shown", shown_count, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/user_status_beacon.md
# user_status_beacon

Sequences 16-bit check words and 4-bit status codes out of the user project onto the GPIO pins that off-chip monitors sample (check field on mprj_io[31:16], status field on mprj_io[35:32]). Firmware, or user logic behind a Wishbone slave, pushes words into a small FIFO. The beacon presents each word for a programmable minimum number of clock cycles, so a slower external sampler reliably sees every code. It sits inside user_project_wrapper and drives io_out/io_oeb for pins 16..35 only.

## Interface
- FIFO_DEPTH, 4: entries in the word FIFO; power of two, at least 2.
- HOLD_W, 16: width of the hold-cycle count.
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- enable  in  1  beacon on; low tri-states the pins and flushes the FIFO.
- hold_cycles  in  HOLD_W  cycles each word is shown; 0 is treated as 1; sampled at pop.
- push_valid  in  1  push request.
- push_ready  out  1  push accepted when push_valid && push_ready.
- push_check  in  16  check word to display.
- push_status  in  4  status code to display.
- checkbits_o  out  16  drives io_out[31:16].
- status_o  out  4  drives io_out[35:32].
- oeb_o  out  20  drives io_oeb[35:16]; 1 means input.
- word_done  out  1  one-cycle pulse in the last hold cycle of each word.
- shown_count  out  8  count of words presented; wraps 255→0.

## Operation
- Reset values: checkbits_o=0, status_o=0, oeb_o=all 1s, push_ready=0, word_done=0, shown_count=0. The FIFO is empty and the FSM is in IDLE.
- oeb_o is a register: it becomes all 0s one cycle after enable rises and all 1s one cycle after enable falls.
- push_ready = enable && !full. It is computed from the current occupancy, so a pop in the same cycle does not free a slot.
- FSM state IDLE:
  - checkbits_o and status_o hold their last values.
  - If enable && !empty: pop the head into the output registers, load the counter with max(hold_cycles,1), increment shown_count, and go to HOLD.
- FSM state HOLD:
  - The counter decrements each cycle. word_done is asserted in the cycle where the counter equals 1.
  - At that cycle, if the FIFO is non-empty, pop the next word back-to-back (stay in HOLD, reload the counter). Otherwise go to IDLE and keep the word on the pins.
- enable low in any state: next state IDLE, the FIFO is flushed, and the counter is cleared. checkbits_o and status_o keep their current values. No word_done pulse is issued for an aborted word.
- A push and a pop may occur in the same cycle when the FIFO is neither full nor empty; occupancy is unchanged.
- A push into an empty FIFO is not visible to the FSM until the next cycle; there is no bypass.
- Wrap-around:
  - The FIFO pointers wrap modulo FIFO_DEPTH.
  - The occupancy counter is log2(FIFO_DEPTH)+1 bits.
  - shown_count wraps 255→0 silently.
- hold_cycles may change at any time; only the value sampled at pop applies to that word.

## Timing
- Push accepted at edge E with the beacon IDLE and the FIFO empty: the word appears on checkbits_o/status_o after edge E+2 (the pop happens at E+1 and the output updates at E+2).
- Each word is shown for exactly max(hold_cycles,1) cycles when the next word is already queued. Back-to-back words have no gap cycle.
- word_done is asserted in the final display cycle of the word, one cycle before the next word appears or before the FSM enters IDLE.
- Sustained throughput is one word per max(hold_cycles,1) cycles. With hold=1 this is one word per cycle.

## Structure
- Shared package user_beacon_pkg holds:
  - the state enum (IDLE, HOLD);
  - the beacon_word_t struct {check[15:0], status[3:0]};
  - the pin constants CHECK_LSB=16, STATUS_LSB=32.
- One sub-module, user_beacon_fifo: a synchronous FIFO with parameters FIFO_DEPTH and width 20, synchronous active-high reset, flush input, and full/empty/count outputs.
- The top level contains the FSM, hold counter, output registers, oeb register and shown_count.

## Test plan
- Reset: hold wb_rst_i for 3 cycles with enable=1 → all outputs at their reset values, push_ready=0 during reset and 1 in the cycle after release.
- hold=3; push {AB40,A} then {1968,5} back-to-back → checkbits_o=AB40/status_o=A for exactly 3 cycles starting 2 cycles after the first push. Then 1968/5 for 3 cycles, then held. Two word_done pulses; shown_count=2.
- hold=0; push {1DCD,5},{1DCE,5},{AB51,A} → each word shown for 1 cycle, consecutively.
- Full FIFO: hold=10; push 5 words with push_valid held high → push_ready drops after the FIFO fills (the first word is popped early, so 5 words fit). The sixth push is stalled until the first word_done pop, and no word is lost or duplicated.
- Abort: enable low in the 2nd cycle of a hold=8 word with 2 words queued → oeb_o=all 1s the next cycle, pins keep that word, no word_done, FIFO empty. Re-enable and push {1234,3} → that word appears with shown_count=2.
- Wrap: push 257 words with hold=1 → shown_count=1, and every word is displayed in order.
